pe_net_interface: RTL and testbench

//  Network interface between one PE and its NoC switch port. Buffers PE-injected packets
//  {dest[31:24],payload[23:0]} in a TX FIFO and forwards remote ones to the switch.

---
 rtl/pe_net_interface_if.sv | 30 +++
 rtl/pe_net_interface.sv | 127 ++++++++++++
 tb/tb_pe_net_interface.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pe_net_interface_if.sv
// PE/switch handshake bundle for the network interface.
// master: the interface block itself; slave: the PE and switch environment around it.
interface pe_net_interface_if;
  logic [31:0] i_pe_data;
  logic        i_pe_data_valid;
  logic        o_pe_data_ready;
  logic [31:0] o_pe_data;
  logic        o_pe_data_valid;
  logic        i_pe_data_ready;
  logic [31:0] o_net_data;
  logic        o_net_data_valid;
  logic        i_net_data_ready;
  logic [31:0] i_net_data;
  logic        i_net_data_valid;
  logic        o_net_data_ready;

  modport master (
    input  i_pe_data, i_pe_data_valid, i_pe_data_ready,
    input  i_net_data, i_net_data_valid, i_net_data_ready,
    output o_pe_data_ready, o_pe_data, o_pe_data_valid,
    output o_net_data, o_net_data_valid, o_net_data_ready
  );

  modport slave (
    output i_pe_data, i_pe_data_valid, i_pe_data_ready,
    output i_net_data, i_net_data_valid, i_net_data_ready,
    input  o_pe_data_ready, o_pe_data, o_pe_data_valid,
    input  o_net_data, o_net_data_valid, o_net_data_ready
  );
endinterface

// File: rtl/pe_net_interface.sv
// PE <-> NoC network interface: in-order TX FIFO, remote forwarding, local loopback
// and round-robin merge of loopback with switch traffic into the PE-bound stream.
module pe_net_interface #(
  parameter int ADDRESS    = 0,
  parameter int NUM_PE     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  pe_net_interface_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [15:0]                   o_tx_count,
  output logic [15:0]                   o_rx_count,
  output logic [15:0]                   o_drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [8:0] NUM_PE_L = 9'(NUM_PE);
  localparam logic [7:0] ADDR_L   = 8'(ADDRESS);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          net_vld_q, pe_vld_q, rr_net_q;
  logic [31:0]   net_data_q, pe_data_q;
  logic [15:0]   tx_cnt_q, rx_cnt_q, drop_cnt_q;

  logic        full, empty, push, pop;
  logic        head_drop, head_local, head_remote;
  logic        net_can_load, pe_can_load, contended;
  logic        grant_net, grant_local, net_load, pe_load;
  logic [31:0] head;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.i_pe_data_valid & ~full;

  always_comb begin
    head_drop   = 1'b0;
    head_local  = 1'b0;
    head_remote = 1'b0;
    if (!empty) begin
      if ({1'b0, head[31:24]} >= NUM_PE_L) head_drop   = 1'b1;
      else if (head[31:24] == ADDR_L)      head_local  = 1'b1;
      else                                 head_remote = 1'b1;
    end
  end

  // An output register can take new data when empty or being drained on this edge.
  assign net_can_load = ~net_vld_q | bus.i_net_data_ready;
  assign pe_can_load  = ~pe_vld_q  | bus.i_pe_data_ready;

  assign contended   = head_local & bus.i_net_data_valid;
  assign grant_net   = bus.i_net_data_valid & (~head_local | rr_net_q);
  assign grant_local = head_local & ~grant_net;

  assign net_load = head_remote & net_can_load;
  assign pe_load  = pe_can_load & (grant_net | grant_local);
  assign pop      = head_drop | net_load | (grant_local & pe_can_load);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array carries no reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_pe_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      net_vld_q  <= 1'b0;
      net_data_q <= '0;
      pe_vld_q   <= 1'b0;
      pe_data_q  <= '0;
      rr_net_q   <= 1'b1;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      if (net_load) begin
        net_vld_q  <= 1'b1;
        net_data_q <= head;
      end else if (bus.i_net_data_ready) begin
        net_vld_q  <= 1'b0;
      end

      if (pe_load) begin
        pe_vld_q  <= 1'b1;
        pe_data_q <= grant_net ? bus.i_net_data : head;
      end else if (bus.i_pe_data_ready) begin
        pe_vld_q  <= 1'b0;
      end

      // The loser of a contended grant gets priority next time.
      if (contended && pe_can_load) rr_net_q <= grant_local;

      if (net_vld_q && bus.i_net_data_ready) tx_cnt_q   <= tx_cnt_q + 1'b1;
      if (pe_vld_q && bus.i_pe_data_ready)   rx_cnt_q   <= rx_cnt_q + 1'b1;
      if (head_drop)                         drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.o_pe_data_ready  = ~full;
  assign bus.o_net_data_ready = pe_can_load & grant_net;
  assign bus.o_net_data       = net_data_q;
  assign bus.o_net_data_valid = net_vld_q;
  assign bus.o_pe_data        = pe_data_q;
  assign bus.o_pe_data_valid  = pe_vld_q;
  assign o_fifo_count         = cnt_q;
  assign o_tx_count           = tx_cnt_q;
  assign o_rx_count           = rx_cnt_q;
  assign o_drop_count         = drop_cnt_q;
endmodule

// File: tb/tb_pe_net_interface.sv
// Randomized bench for pe_net_interface against a packet-level queue model.
module tb_pe_net_interface;
  localparam int ADDR  = 3;
  localparam int NPE   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fifo_count;
  logic [15:0] tx_count, rx_count, drop_count;

  pe_net_interface_if bus ();

  pe_net_interface #(.ADDRESS(ADDR), .NUM_PE(NPE), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .o_fifo_count (fifo_count),
    .o_tx_count   (tx_count),
    .o_rx_count   (rx_count),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: TX queue, two output slots, round-robin memory, counters.
  logic [31:0] mq[$];
  bit          m_nv, m_pv, m_net_first;
  logic [31:0] m_nd, m_pd;
  logic [15:0] m_tx, m_rx, m_drop;
  bit          pe_pending, sw_pending;

  task automatic model_reset();
    mq.delete();
    m_nv = 0; m_pv = 0; m_nd = '0; m_pd = '0;
    m_net_first = 1;
    m_tx = '0; m_rx = '0; m_drop = '0;
    pe_pending = 0; sw_pending = 0;
  endtask

  function automatic logic [31:0] gen_pkt(input int mode);
    logic [7:0] d;
    int r;
    r = $urandom_range(0, 3);
    if (mode == 2)       d = 8'(ADDR);
    else if (mode == 1)  d = 8'(5);
    else if (r == 0)     d = 8'(ADDR);
    else if (r == 1)     d = 8'($urandom_range(NPE, 255));
    else                 d = 8'($urandom_range(0, NPE - 1));
    return {d, 24'($urandom)};
  endfunction

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_net_valid"}, 32'(bus.o_net_data_valid), 32'd0);
    check_eq({pfx, "_pe_valid"},  32'(bus.o_pe_data_valid),  32'd0);
    check_eq({pfx, "_net_data"},  bus.o_net_data,            32'd0);
    check_eq({pfx, "_pe_data"},   bus.o_pe_data,             32'd0);
    check_eq({pfx, "_fifo_cnt"},  32'(fifo_count),           32'd0);
    check_eq({pfx, "_tx"},        32'(tx_count),             32'd0);
    check_eq({pfx, "_rx"},        32'(rx_count),             32'd0);
    check_eq({pfx, "_drop"},      32'(drop_count),           32'd0);
    check_eq({pfx, "_pe_ready"},  32'(bus.o_pe_data_ready),  32'd1);
  endtask

  // mode 0: random mix, 1: switch stalled with remote stream, 2: loopback vs switch
  // every cycle with all sinks ready, 3: both sinks stalled.
  task automatic step(input int mode);
    bit full, is_drop, is_loc, is_rem, pe_free, net_free, sw_req, sw_wins, loc_wins, acc_pe;
    logic [31:0] head;
    @(negedge clk);
    if (!pe_pending) begin
      bus.i_pe_data_valid = (mode == 1 || mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.i_pe_data       = gen_pkt(mode);
    end
    if (!sw_pending) begin
      bus.i_net_data_valid = (mode == 2) ? 1'b1 : (mode == 1 ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.i_net_data       = $urandom;
    end
    case (mode)
      1:       begin bus.i_net_data_ready = 1'b0; bus.i_pe_data_ready = 1'($urandom_range(0, 1)); end
      2:       begin bus.i_net_data_ready = 1'b1; bus.i_pe_data_ready = 1'b1; end
      3:       begin bus.i_net_data_ready = 1'b0; bus.i_pe_data_ready = 1'b0; end
      default: begin bus.i_net_data_ready = 1'($urandom_range(0, 1)); bus.i_pe_data_ready = 1'($urandom_range(0, 1)); end
    endcase
    #1;
    full = (mq.size() == DEPTH);
    head = (mq.size() > 0) ? mq[0] : 32'd0;
    is_drop = (mq.size() > 0) && (int'(head[31:24]) >= NPE);
    is_loc  = (mq.size() > 0) && !is_drop && (int'(head[31:24]) == ADDR);
    is_rem  = (mq.size() > 0) && !is_drop && !is_loc;
    pe_free  = !m_pv || bus.i_pe_data_ready;
    net_free = !m_nv || bus.i_net_data_ready;
    sw_req   = bus.i_net_data_valid;
    sw_wins  = sw_req && (!is_loc || m_net_first);
    loc_wins = is_loc && !sw_wins;

    check_eq("pe_ready",   32'(bus.o_pe_data_ready),  32'(!full));
    check_eq("fifo_count", 32'(fifo_count),           32'(mq.size()));
    check_eq("net_valid",  32'(bus.o_net_data_valid), 32'(m_nv));
    if (m_nv) check_eq("net_data", bus.o_net_data, m_nd);
    check_eq("pe_valid",   32'(bus.o_pe_data_valid),  32'(m_pv));
    if (m_pv) check_eq("pe_data", bus.o_pe_data, m_pd);
    check_eq("net_ready",  32'(bus.o_net_data_ready), 32'(pe_free && sw_wins));
    check_eq("tx_count",   32'(tx_count),             32'(m_tx));
    check_eq("rx_count",   32'(rx_count),             32'(m_rx));
    check_eq("drop_count", 32'(drop_count),           32'(m_drop));

    // Advance the model to the state after the coming posedge.
    if (m_nv && bus.i_net_data_ready) begin m_tx++; m_nv = 0; end
    if (m_pv && bus.i_pe_data_ready)  begin m_rx++; m_pv = 0; end
    if (is_drop) begin
      m_drop++; void'(mq.pop_front());
    end else if (is_rem && net_free) begin
      m_nv = 1; m_nd = head; void'(mq.pop_front());
    end else if (loc_wins && pe_free) begin
      m_pv = 1; m_pd = head; void'(mq.pop_front());
    end
    if (sw_wins && pe_free) begin m_pv = 1; m_pd = bus.i_net_data; end
    if (is_loc && sw_req && pe_free) m_net_first = loc_wins;
    acc_pe = bus.i_pe_data_valid && !full;
    if (acc_pe) mq.push_back(bus.i_pe_data);
    pe_pending = bus.i_pe_data_valid && !acc_pe;
    sw_pending = sw_req && !(sw_wins && pe_free);
  endtask

  task automatic apply_reset(input string pfx);
    @(negedge clk);
    rst = 1'b1;
    bus.i_pe_data_valid  = 1'b0;
    bus.i_net_data_valid = 1'b0;
    #1;
    check_reset_state(pfx);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_pe_data = '0;   bus.i_pe_data_valid = 1'b0; bus.i_pe_data_ready = 1'b1;
    bus.i_net_data = '0;  bus.i_net_data_valid = 1'b0; bus.i_net_data_ready = 1'b1;
    model_reset();
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) step(0);
    for (int i = 0; i < 20; i++)  step(1);
    for (int i = 0; i < 60; i++)  step(0);
    for (int i = 0; i < 40; i++)  step(2);
    for (int i = 0; i < 200; i++) step(0);
    for (int i = 0; i < 12; i++)  step(3);
    apply_reset("midrst");
    for (int i = 0; i < 300; i++) step(0);
    for (int i = 0; i < 30; i++)  step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
